// File: rtl/aes_pkg.sv
// Shared AES primitives: S-box, GF(2^8) helpers, Rcon and the iterative-core FSM state type.
package aes_pkg;

    localparam int unsigned NB = 4;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [2:0] {
        ST_NOKEY,
        ST_KEY_EXP,
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } aes_state_e;

    localparam logic [2047:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bits [2047-8b -: 8]; 2047-8b == {~b, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_ROM[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] j);
        logic [7:0] r;
        case (j)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_encrypt_iter_if.sv
// Key load, plaintext in and ciphertext out handshakes of the iterative AES encryptor.
interface aes_encrypt_iter_if
    import aes_pkg::*;
#(
    parameter int unsigned Nk = 4
) ();

    logic [32*Nk-1:0] key_in;
    logic             key_load;
    logic             key_ready;
    logic             in_valid;
    logic             in_ready;
    aes_block_t       data_in;
    logic             out_valid;
    logic             out_ready;
    aes_block_t       data_out;
    logic             busy;

    modport master (
        output key_in, key_load, in_valid, data_in, out_ready,
        input  key_ready, in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  key_in, key_load, in_valid, data_in, out_ready,
        output key_ready, in_ready, out_valid, data_out, busy
    );

endinterface

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns (skipped when last), AddRoundKey.
module aes_enc_round
    import aes_pkg::*;
(
    input  aes_block_t blk,
    input  aes_block_t rkey,
    input  logic       last,
    output aes_block_t result
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // Byte b is row b%4, column b/4; row r rotates left by r columns.
    for (genvar b = 0; b < 16; b++) begin : g_byte
        assign sb[b] = sbox(blk[127-8*b -: 8]);
        assign sr[b] = sb[(b % 4) + 4 * (((b / 4) + (b % 4)) % 4)];
        assign result[127-8*b -: 8] = (last ? sr[b] : mc[b]) ^ rkey[127-8*b -: 8];
    end

    for (genvar c = 0; c < NB; c++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr[4*c];
        assign a1 = sr[4*c+1];
        assign a2 = sr[4*c+2];
        assign a3 = sr[4*c+3];
        assign mc[4*c]   = xtime(a0) ^ gmul3(a1) ^ a2 ^ a3;
        assign mc[4*c+1] = a0 ^ xtime(a1) ^ gmul3(a2) ^ a3;
        assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ gmul3(a3);
        assign mc[4*c+3] = gmul3(a0) ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryptor: word-per-cycle key expansion, then one round per cycle.
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input logic              clk,
    input logic              rst_n,
    aes_encrypt_iter_if.slave bus
);

    localparam int unsigned NW = 4 * (Nr + 1);
    localparam int unsigned IW = $clog2(NW);
    localparam int unsigned CW = 3;
    localparam int unsigned RW = 4;

    aes_state_e fsm, fsm_next;

    logic          load_key, exp_step, accept, round_step, out_take;
    logic          in_ready_c, busy_c;
    logic [IW-1:0] widx, rk_base;
    logic [CW-1:0] col;
    logic [3:0]    rc_idx;
    logic [RW-1:0] rnd;
    logic          key_ready, out_valid;
    aes_block_t    data_out, blk, round_key, round_out;
    logic [31:0]   w [NW];
    logic [31:0]   prev_word, temp;
    logic          exp_last, last_round;

    assign exp_last   = (widx == IW'(NW - 1));
    assign last_round = (rnd == RW'(Nr));

    always_ff @(posedge clk) begin
        if (!rst_n) fsm <= ST_NOKEY;
        else        fsm <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm;
        unique case (fsm)
            ST_NOKEY:   if (bus.key_load) fsm_next = ST_KEY_EXP;
            ST_KEY_EXP: if (!bus.key_load && exp_last) fsm_next = ST_IDLE;
            ST_IDLE: begin
                if (bus.in_valid)      fsm_next = ST_ROUND;
                else if (bus.key_load) fsm_next = ST_KEY_EXP;
            end
            ST_ROUND:   if (last_round) fsm_next = ST_DONE;
            ST_DONE:    if (bus.out_ready) fsm_next = ST_IDLE;
            default:    fsm_next = ST_NOKEY;
        endcase
    end

    // An accepted block wins over a simultaneous key_load so the input handshake is never dropped.
    always_comb begin
        load_key   = 1'b0;
        exp_step   = 1'b0;
        accept     = 1'b0;
        round_step = 1'b0;
        out_take   = 1'b0;
        in_ready_c = 1'b0;
        busy_c     = 1'b0;
        unique case (fsm)
            ST_NOKEY: load_key = bus.key_load;
            ST_KEY_EXP: begin
                busy_c   = 1'b1;
                load_key = bus.key_load;
                exp_step = !bus.key_load;
            end
            ST_IDLE: begin
                in_ready_c = 1'b1;
                accept     = bus.in_valid;
                load_key   = bus.key_load && !bus.in_valid;
            end
            ST_ROUND: begin
                busy_c     = 1'b1;
                round_step = 1'b1;
            end
            ST_DONE: begin
                busy_c   = 1'b1;
                out_take = bus.out_ready;
            end
            default: ;
        endcase
    end

    always_comb begin
        prev_word = w[widx - IW'(1)];
        if (col == '0)
            temp = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon(rc_idx), 24'h0};
        else if (Nk == 8 && col == CW'(4))
            temp = sub_word(prev_word);
        else
            temp = prev_word;
    end

    always_comb begin
        rk_base   = IW'({rnd, 2'b00});
        round_key = {w[rk_base], w[rk_base + IW'(1)], w[rk_base + IW'(2)], w[rk_base + IW'(3)]};
    end

    aes_enc_round u_round (
        .blk    (blk),
        .rkey   (round_key),
        .last   (last_round),
        .result (round_out)
    );

    // Control counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            widx      <= '0;
            col       <= '0;
            rc_idx    <= '0;
            rnd       <= '0;
            key_ready <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            if (load_key) begin
                widx      <= IW'(Nk);
                col       <= '0;
                rc_idx    <= 4'd1;
                key_ready <= 1'b0;
            end else if (exp_step) begin
                if (exp_last) key_ready <= 1'b1;
                else          widx      <= widx + IW'(1);
                col <= (col == CW'(Nk - 1)) ? '0 : col + CW'(1);
                if (col == '0) rc_idx <= rc_idx + 4'd1;
            end
            if (accept) begin
                rnd <= RW'(1);
            end else if (round_step) begin
                if (last_round) begin
                    rnd       <= '0;
                    data_out  <= round_out;
                    out_valid <= 1'b1;
                end else begin
                    rnd <= rnd + RW'(1);
                end
            end
            if (out_take) out_valid <= 1'b0;
        end
    end

    // Key schedule and cipher state carry no reset; their contents only matter once rewritten.
    always_ff @(posedge clk) begin
        if (load_key) begin
            for (int k = 0; k < int'(Nk); k++)
                w[k] <= bus.key_in[32*(int'(Nk)-1-k) +: 32];
        end else if (exp_step) begin
            w[widx] <= w[widx - IW'(Nk)] ^ temp;
        end
        if (accept)          blk <= bus.data_in ^ {w[0], w[1], w[2], w[3]};
        else if (round_step) blk <= round_out;
    end

    assign bus.key_ready = key_ready;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid;
    assign bus.data_out  = data_out;
    assign bus.busy      = busy_c;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: FIPS-197 vectors, protocol corner cases and random blocks vs a byte-level model.
module tb_aes_encrypt_iter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_encrypt_iter_if #(.Nk(4)) b4 ();
    aes_encrypt_iter_if #(.Nk(6)) b6 ();
    aes_encrypt_iter_if #(.Nk(8)) b8 ();

    aes_encrypt_iter #(.Nk(4), .Nr(10)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    aes_encrypt_iter #(.Nk(6), .Nr(12)) u6 (.clk(clk), .rst_n(rst_n), .bus(b6));
    aes_encrypt_iter #(.Nk(8), .Nr(14)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    // Index 0/1/2 selects the AES-128/192/256 instance.
    logic [255:0] key_v [3];
    logic         key_load_v [3];
    logic         in_valid_v [3];
    logic [127:0] din_v [3];
    logic         out_ready_v [3];
    logic         key_ready_v [3];
    logic         in_ready_v [3];
    logic         out_valid_v [3];
    logic [127:0] dout_v [3];
    logic         busy_v [3];

    assign b4.key_in = key_v[0][127:0];
    assign b6.key_in = key_v[1][191:0];
    assign b8.key_in = key_v[2];
    assign b4.key_load = key_load_v[0];  assign b6.key_load = key_load_v[1];  assign b8.key_load = key_load_v[2];
    assign b4.in_valid = in_valid_v[0];  assign b6.in_valid = in_valid_v[1];  assign b8.in_valid = in_valid_v[2];
    assign b4.data_in = din_v[0];        assign b6.data_in = din_v[1];        assign b8.data_in = din_v[2];
    assign b4.out_ready = out_ready_v[0]; assign b6.out_ready = out_ready_v[1]; assign b8.out_ready = out_ready_v[2];
    assign key_ready_v[0] = b4.key_ready; assign key_ready_v[1] = b6.key_ready; assign key_ready_v[2] = b8.key_ready;
    assign in_ready_v[0] = b4.in_ready;   assign in_ready_v[1] = b6.in_ready;   assign in_ready_v[2] = b8.in_ready;
    assign out_valid_v[0] = b4.out_valid; assign out_valid_v[1] = b6.out_valid; assign out_valid_v[2] = b8.out_valid;
    assign dout_v[0] = b4.data_out;       assign dout_v[1] = b6.data_out;       assign dout_v[2] = b8.data_out;
    assign busy_v[0] = b4.busy;           assign busy_v[1] = b6.busy;           assign busy_v[2] = b8.busy;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (GF arithmetic, S-box derived from the field inverse) ----------------
    logic [7:0] sbt [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word_ref(input logic [31:0] x);
        return {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]};
    endfunction

    function automatic logic [127:0] ref_encrypt(input int nk, input logic [255:0] key, input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [7:0]   rc, s [16], u [16];
        logic [127:0] ct;
        int nr, nw;
        nr = nk + 6;
        nw = 4 * (nr + 1);
        for (int i = 0; i < nk; i++) w[i] = key[32*(nk-1-i) +: 32];
        rc = 8'h01;
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word_ref(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int b = 0; b < 16; b++) u[b] = sbt[s[(b%4) + 4*(((b/4) + (b%4)) % 4)]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    s[4*c+j] = (r < nr) ? gmul(8'h02, u[4*c+j]) ^ gmul(8'h03, u[4*c+(j+1)%4])
                                          ^ u[4*c+(j+2)%4] ^ u[4*c+(j+3)%4]
                                        : u[4*c+j];
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) ct[127-8*b -: 8] = s[b];
        return ct;
    endfunction

    // ---------------- drivers (entered and left on a falling edge) ----------------
    task automatic pulse_key(input int sel, input logic [255:0] key);
        key_v[sel]      = key;
        key_load_v[sel] = 1'b1;
        @(negedge clk);
        key_load_v[sel] = 1'b0;
    endtask

    task automatic wait_key(input int sel, output int lat);
        lat = 0;
        while (!key_ready_v[sel] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic send(input int sel, input logic [127:0] pt);
        int n = 0;
        din_v[sel]      = pt;
        in_valid_v[sel] = 1'b1;
        while (!in_ready_v[sel] && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid_v[sel] = 1'b0;
    endtask

    task automatic collect(input int sel, output logic [127:0] ct, output int lat);
        lat = 0;
        while (!out_valid_v[sel] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        ct               = dout_v[sel];
        out_ready_v[sel] = 1'b1;
        @(negedge clk);
        out_ready_v[sel] = 1'b0;
    endtask

    function automatic logic [255:0] rand_key(input int nk);
        logic [255:0] k = '0;
        for (int i = 0; i < nk; i++) k = {k[223:0], 32'($urandom)};
        return k;
    endfunction

    function automatic logic [127:0] rand_blk();
        return {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;
    logic [255:0] kat_key [3] = '{256'h000102030405060708090a0b0c0d0e0f,
                                  256'h000102030405060708090a0b0c0d0e0f1011121314151617,
                                  256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f};
    logic [127:0] kat_ct [3]  = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                  128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                                  128'h8ea2b7ca516745bfeafc49904b496089};

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat, nk, nr;
        logic [127:0] ct, pt, exp_ct;
        logic [255:0] key;

        for (int i = 0; i < 256; i++) sbt[i] = sbox_calc(8'(i));
        for (int s = 0; s < 3; s++) begin
            key_v[s] = '0; key_load_v[s] = 1'b0; in_valid_v[s] = 1'b0;
            din_v[s] = '0; out_ready_v[s] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check_val($sformatf("rst%0d_key_ready", s), 128'(key_ready_v[s]), 128'(0));
            check_val($sformatf("rst%0d_in_ready", s), 128'(in_ready_v[s]), 128'(0));
            check_val($sformatf("rst%0d_out_valid", s), 128'(out_valid_v[s]), 128'(0));
            check_val($sformatf("rst%0d_data_out", s), dout_v[s], 128'(0));
            check_val($sformatf("rst%0d_busy", s), 128'(busy_v[s]), 128'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 appendix C known answers with expansion and round latencies
        for (int s = 0; s < 3; s++) begin
            nk = 4 + 2 * s;
            nr = nk + 6;
            pulse_key(s, kat_key[s]);
            wait_key(s, lat);
            check_val($sformatf("kat%0d_key_latency", s), 128'(lat), 128'(4 * (nr + 1) - nk));
            send(s, KAT_PT);
            collect(s, ct, lat);
            check_val($sformatf("kat%0d_ciphertext", s), ct, kat_ct[s]);
            check_val($sformatf("kat%0d_latency", s), 128'(lat), 128'(nr));
        end

        // backpressure: output held, second block waits for the handshake
        pulse_key(0, 256'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_key(0, lat);
        send(0, 128'h3243f6a8885a308d313198a2e0370734);
        lat = 0;
        while (!out_valid_v[0] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_val("bp_latency", 128'(lat), 128'(10));
        pt = rand_blk();
        din_v[0] = pt;
        in_valid_v[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_val("bp_data_hold", dout_v[0], 128'h3925841d02dc09fbdc118597196a0b32);
            check_val("bp_valid_hold", 128'(out_valid_v[0]), 128'(1));
            check_val("bp_in_ready_low", 128'(in_ready_v[0]), 128'(0));
            @(negedge clk);
        end
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        out_ready_v[0] = 1'b0;
        check_val("bp_valid_dropped", 128'(out_valid_v[0]), 128'(0));
        check_val("bp_in_ready_after", 128'(in_ready_v[0]), 128'(1));
        check_val("bp_data_kept", dout_v[0], 128'h3925841d02dc09fbdc118597196a0b32);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        check_val("bp_second_accepted", 128'(in_ready_v[0]), 128'(0));
        collect(0, ct, lat);
        check_val("bp_second_ct", ct, ref_encrypt(4, 256'h2b7e151628aed2a6abf7158809cf4f3c, pt));
        check_val("bp_second_latency", 128'(lat), 128'(10));

        // key_load during expansion restarts with the new key
        pulse_key(1, rand_key(6));
        repeat (10) @(negedge clk);
        key = rand_key(6);
        pulse_key(1, key);
        wait_key(1, lat);
        check_val("restart_key_latency", 128'(lat), 128'(46));
        pt = rand_blk();
        send(1, pt);
        collect(1, ct, lat);
        check_val("restart_ct", ct, ref_encrypt(6, key, pt));

        // key_load during ROUND is ignored
        key = rand_key(8);
        pulse_key(2, key);
        wait_key(2, lat);
        pt = rand_blk();
        send(2, pt);
        pulse_key(2, rand_key(8));
        collect(2, ct, lat);
        check_val("round_keyload_ct", ct, ref_encrypt(8, key, pt));
        check_val("round_keyload_latency", 128'(lat), 128'(13));
        check_val("round_keyload_key_ready", 128'(key_ready_v[2]), 128'(1));

        // synchronous reset while round 5 is being computed
        send(0, rand_blk());
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_out_valid", 128'(out_valid_v[0]), 128'(0));
        check_val("midrst_key_ready", 128'(key_ready_v[0]), 128'(0));
        check_val("midrst_in_ready", 128'(in_ready_v[0]), 128'(0));
        check_val("midrst_data_out", dout_v[0], 128'(0));
        check_val("midrst_busy", 128'(busy_v[0]), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // random key/plaintext pairs against the model
        for (int s = 0; s < 3; s++) begin
            nk = 4 + 2 * s;
            nr = nk + 6;
            for (int t = 0; t < 150; t++) begin
                key = rand_key(nk);
                pt  = rand_blk();
                exp_ct = ref_encrypt(nk, key, pt);
                pulse_key(s, key);
                wait_key(s, lat);
                check_val($sformatf("rnd%0d_key_latency", s), 128'(lat), 128'(4 * (nr + 1) - nk));
                send(s, pt);
                collect(s, ct, lat);
                check_val($sformatf("rnd%0d_ct", s), ct, exp_ct);
                check_val($sformatf("rnd%0d_latency", s), 128'(lat), 128'(nr));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
